riscv_uart_tx: RTL
==================

RISCV_UART_TX -- requirements
Module: riscv_uart_tx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); SHALL be >= 2.
REQ-002: Parameter FIFO_DEPTH, default 16, byte entries in the transmit FIFO; SHALL be a power of two >= 2.
REQ-003: Port i_riscv_uart_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: Port i_riscv_uart_rst  input  1  reset, asynchronous assert, active-low.
REQ-005: Port i_riscv_uart_tx_data  input  8  byte from the core store path (core storedata bits [7:0]).
REQ-006: Port i_riscv_uart_tx_valid  input  1  one-cycle write strobe from the core.
REQ-007: Port o_riscv_uart_fifo_full  output  1  FIFO holds FIFO_DEPTH bytes; the core stalls while high.
REQ-008: Port o_riscv_uart_tx  output  1  serial line, 8N1, idle high.
REQ-009: Port o_riscv_uart_busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-010: FIFO SHALL be a circular buffer: write pointer, read pointer, and occupancy count of width clog2(FIFO_DEPTH)+1; pointers wrap from FIFO_DEPTH-1 to 0.
REQ-011: Push SHALL occur on an edge where tx_valid=1 and fifo_full=0; the byte is written at the write pointer.
REQ-012: tx_valid=1 while fifo_full=1 SHALL be ignored: byte dropped, no pointer or count change, no error flag. This holds even if a pop occurs on the same edge.
REQ-013: fifo_full SHALL be registered and equal (count==FIFO_DEPTH) after each edge; it deasserts on the edge after the pop from full.
REQ-014: Push and pop on the same edge with the FIFO non-full SHALL leave count unchanged and advance both pointers.
REQ-015: FSM states: IDLE, START, DATA, STOP; a bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1).
REQ-016: IDLE: tx=1. If count>0, pop the head into an 8-bit shift register, clear the baud counter, and go to START on that edge. If count=0, stay in IDLE.
REQ-017: START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
REQ-018: DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. On each bit end, shift right and increment the bit counter. After bit 7, go to STOP.
REQ-019: STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-020: Frame period SHALL be 10*CLKS_PER_BIT cycles plus 1 IDLE cycle between back-to-back frames.
REQ-021: o_riscv_uart_tx SHALL be driven from a flop (glitch-free); it changes one cycle after the state/bit transition edge, consistently for all bits.
REQ-022: Pushes during a frame SHALL NOT disturb the byte in the shift register.
REQ-023: An empty FIFO SHALL never be popped; pop occurs only in IDLE with count>0.

Reset
REQ-024: While i_riscv_uart_rst=0, the block SHALL asynchronously force: FSM=IDLE, pointers/count/counters=0, shift register=0, tx=1, fifo_full=0, busy=0.
REQ-025: Reset asserted mid-frame SHALL abort the frame immediately (tx=1) and discard all FIFO contents.
REQ-026: After reset release, the first push is accepted on the first rising edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=16)
REQ-027: Single byte 0xA5 pushed -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy falls after STOP; total 40 cycles of frame.
REQ-028: 17 consecutive pushes 0x00..0x10 with no drain opportunity beyond the first pop -> first byte enters the shift register, 16 are stored, fifo_full=1. Then a push of 0xFF while full is dropped; serialized output is 0x00..0x10 in order with no 0xFF.
REQ-029: Push on the same edge as the IDLE pop with count=1 -> count stays 1, second byte transmitted after 1 idle cycle; frames back-to-back at 41-cycle spacing.
REQ-030: Pointer wrap: 40 bytes streamed with continuous refill -> all 40 bytes received in order and intact by a bench 8N1 sampler at mid-bit.
REQ-031: Reset asserted in DATA bit 3 of a frame with 5 bytes queued -> tx=1 immediately, fifo_full=0, busy=0. After release, no residual frame appears; a new byte 0x3C transmits correctly.

Source files
------------

// File: rtl/riscv_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : riscv_uart_tx
// Purpose  : Byte-wide UART transmitter for a RISC-V core store path.
//            Bytes go into a circular FIFO and are serialized as 8N1,
//            LSB first, idle high. The serial line is driven from a flop.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       i_riscv_uart_clk,
   input  logic       i_riscv_uart_rst,
   input  logic [7:0] i_riscv_uart_tx_data,
   input  logic       i_riscv_uart_tx_valid,
   output logic       o_riscv_uart_fifo_full,
   output logic       o_riscv_uart_tx,
   output logic       o_riscv_uart_busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                full_q, full_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic [7:0]          mem_q [FIFO_DEPTH];
   logic                push, pop, baud_end;

   // FIFO bookkeeping, FSM next state and registered line/busy values
   always_comb begin
      push      = i_riscv_uart_tx_valid && !full_q;
      pop       = (state_q == S_IDLE) && (count_q != '0);
      baud_end  = (baud_q == BAUD_LAST);
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = baud_q;
      shift_d   = shift_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == FULL_CNT);

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d    = '0;
               bit_cnt_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d    = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line level follows the current state one cycle later, for every bit alike
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_q != S_IDLE) || (count_q != '0);
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge i_riscv_uart_clk or negedge i_riscv_uart_rst) begin
      if (!i_riscv_uart_rst) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         bit_cnt_q <= 3'd0;
         baud_q    <= '0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         bit_cnt_q <= bit_cnt_d;
         baud_q    <= baud_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   // FIFO storage; contents are meaningless once the pointers are reset
   always_ff @(posedge i_riscv_uart_clk) begin
      if (push) mem_q[wr_ptr_q] <= i_riscv_uart_tx_data;
   end

   assign o_riscv_uart_fifo_full = full_q;
   assign o_riscv_uart_tx        = tx_q;
   assign o_riscv_uart_busy      = busy_q;

endmodule
`default_nettype wire
